// File: rtl/count_event_monitor.sv
// count_event_monitor: watches an up/down counter's Q bus and direction, detects
// wrap-around, compare-match and direction-change events, keeps an upper-digit wrap
// count, and queues events in a small valid/ready FIFO for a downstream consumer.
//
// Event handshake: an entry {EVT_CODE, EVT_VALUE} is offered while EVT_VALID is high
// and is consumed on a rising CLK edge where EVT_VALID and EVT_READY are both high;
// the head entry stays stable while EVT_VALID is high and EVT_READY is low.
module count_event_monitor #(
    parameter int WIDTH      = 5,
    parameter int WRAP_WIDTH = 8,
    parameter int EVT_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      Q_IN,
    input  logic                  UP_DOWN,
    input  logic [WIDTH-1:0]      CMP_VAL,
    input  logic                  CMP_LOAD,
    input  logic                  CLR_OVR,
    input  logic                  EVT_READY,
    output logic                  EVT_VALID,
    output logic [1:0]            EVT_CODE,
    output logic [WIDTH-1:0]      EVT_VALUE,
    output logic [WRAP_WIDTH-1:0] WRAP_COUNT,
    output logic                  MATCH_PULSE,
    output logic                  WRAP_PULSE,
    output logic                  OVERRUN,
    output logic [3:0]            DROP_COUNT
);

    localparam int PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + 2;

    localparam logic [1:0] CODE_DIR       = 2'b00;
    localparam logic [1:0] CODE_WRAP_UP   = 2'b01;
    localparam logic [1:0] CODE_WRAP_DOWN = 2'b10;
    localparam logic [1:0] CODE_MATCH     = 2'b11;

    // Sampled history of the counter bus
    logic [WIDTH-1:0]      q_prev_q;
    logic                  dir_prev_q;
    logic                  prev_valid_q;

    // Compare register and arm flag
    logic [WIDTH-1:0]      cmp_reg_q;
    logic                  armed_q;

    // Upper-digit counter and pulses
    logic [WRAP_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                  match_pulse_q;
    logic                  wrap_pulse_q;

    // Lost-event bookkeeping
    logic                  overrun_q, overrun_d;
    logic [3:0]            drop_q, drop_d;

    // Event FIFO
    logic [ENT_W-1:0]      mem_q [EVT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    // Detection and selection
    logic                  wrap_up, wrap_down, match, dir_change;
    logic                  push_sel, push_ok, pop, full;
    logic [1:0]            push_code;
    logic [1:0]            lost_cnt;
    logic [4:0]            drop_sum;
    logic [3:0]            drop_base;

    // Detect events from the current inputs against the registered previous sample
    always_comb begin
        wrap_up    = prev_valid_q && (q_prev_q == '1) && (Q_IN == '0);
        wrap_down  = prev_valid_q && (q_prev_q == '0) && (Q_IN == '1);
        match      = prev_valid_q && armed_q && (Q_IN == cmp_reg_q) && (Q_IN != q_prev_q);
        dir_change = prev_valid_q && (UP_DOWN != dir_prev_q);
    end

    // Pick one event to push (WRAP > MATCH > DIR) and count everything that is lost
    always_comb begin
        push_sel  = 1'b0;
        push_code = CODE_DIR;
        lost_cnt  = 2'd0;
        full      = (count_q == CNT_W'(EVT_DEPTH));
        pop       = EVT_VALID && EVT_READY;
        if (wrap_up || wrap_down) begin
            push_sel  = 1'b1;
            push_code = wrap_up ? CODE_WRAP_UP : CODE_WRAP_DOWN;
            lost_cnt  = 2'(match) + 2'(dir_change);
        end else if (match) begin
            push_sel  = 1'b1;
            push_code = CODE_MATCH;
            lost_cnt  = 2'(dir_change);
        end else if (dir_change) begin
            push_sel  = 1'b1;
            push_code = CODE_DIR;
        end
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok = push_sel && (!full || pop);
        if (push_sel && !push_ok) begin
            lost_cnt = lost_cnt + 2'd1;
        end
    end

    // Next-state for occupancy, wrap counter and the sticky overrun/drop counters
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wrap_cnt_d = wrap_cnt_q;
        if (wrap_up) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_WIDTH'(1);
        end else if (wrap_down) begin
            wrap_cnt_d = wrap_cnt_q - WRAP_WIDTH'(1);
        end

        // Clear first, then fold in this cycle's losses so they are never missed
        drop_base = CLR_OVR ? 4'd0 : drop_q;
        drop_sum  = {1'b0, drop_base} + {3'b000, lost_cnt};
        drop_d    = (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
        overrun_d = (CLR_OVR ? 1'b0 : overrun_q) | (lost_cnt != 2'd0);
    end

    // History, compare register, counters and pulses
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_prev_q      <= '0;
            dir_prev_q    <= 1'b0;
            prev_valid_q  <= 1'b0;
            cmp_reg_q     <= '0;
            armed_q       <= 1'b0;
            wrap_cnt_q    <= '0;
            match_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            overrun_q     <= 1'b0;
            drop_q        <= 4'd0;
        end else begin
            q_prev_q      <= Q_IN;
            dir_prev_q    <= UP_DOWN;
            prev_valid_q  <= 1'b1;
            if (CMP_LOAD) begin
                cmp_reg_q <= CMP_VAL;
                armed_q   <= 1'b1;
            end
            wrap_cnt_q    <= wrap_cnt_d;
            match_pulse_q <= match;
            wrap_pulse_q  <= wrap_up | wrap_down;
            overrun_q     <= overrun_d;
            drop_q        <= drop_d;
        end
    end

    // Event FIFO storage and pointers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < EVT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {push_code, Q_IN};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign EVT_VALID   = (count_q != '0);
    assign EVT_CODE    = mem_q[rd_ptr_q][ENT_W-1:WIDTH];
    assign EVT_VALUE   = mem_q[rd_ptr_q][WIDTH-1:0];
    assign WRAP_COUNT  = wrap_cnt_q;
    assign MATCH_PULSE = match_pulse_q;
    assign WRAP_PULSE  = wrap_pulse_q;
    assign OVERRUN     = overrun_q;
    assign DROP_COUNT  = drop_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor (WIDTH=4, WRAP_WIDTH=4, EVT_DEPTH=4).
// Stimulus pushes the hand-computed expected events into exp_q; a monitor pops
// and compares whenever the DUT hands an event over.
module tb_count_event_monitor;

  localparam int W  = 4;
  localparam int WW = 4;
  localparam int D  = 4;

  localparam logic [1:0] C_DIR   = 2'b00;
  localparam logic [1:0] C_UP    = 2'b01;
  localparam logic [1:0] C_DOWN  = 2'b10;
  localparam logic [1:0] C_MATCH = 2'b11;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  q_in;
  logic          up_down;
  logic [W-1:0]  cmp_val;
  logic          cmp_load;
  logic          clr_ovr;
  logic          evt_ready;
  logic          evt_valid;
  logic [1:0]    evt_code;
  logic [W-1:0]  evt_value;
  logic [WW-1:0] wrap_count;
  logic          match_pulse;
  logic          wrap_pulse;
  logic          overrun;
  logic [3:0]    drop_count;

  logic [W+1:0]  exp_q[$];
  int            checks;
  int            errors;

  count_event_monitor #(.WIDTH(W), .WRAP_WIDTH(WW), .EVT_DEPTH(D)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .Q_IN       (q_in),
    .UP_DOWN    (up_down),
    .CMP_VAL    (cmp_val),
    .CMP_LOAD   (cmp_load),
    .CLR_OVR    (clr_ovr),
    .EVT_READY  (evt_ready),
    .EVT_VALID  (evt_valid),
    .EVT_CODE   (evt_code),
    .EVT_VALUE  (evt_value),
    .WRAP_COUNT (wrap_count),
    .MATCH_PULSE(match_pulse),
    .WRAP_PULSE (wrap_pulse),
    .OVERRUN    (overrun),
    .DROP_COUNT (drop_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: apply inputs just after an edge, return just after the edge that samples them
  task automatic cyc(input int q, input bit ud);
    q_in    = W'(q);
    up_down = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] code, input int val);
    exp_q.push_back({code, W'(val)});
  endtask

  // scoreboard monitor: every accepted handshake must match the oldest expected event
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got code %0d value %0d expected none", evt_code, evt_value);
      end else begin
        e = exp_q.pop_front();
        if ({evt_code, evt_value} != e) begin
          errors++;
          $display("FAIL evt_order: got code %0d value %0d expected code %0d value %0d",
                   evt_code, evt_value, e[W+1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    q_in      = '0;
    up_down   = 1'b0;
    cmp_val   = '0;
    cmp_load  = 1'b0;
    clr_ovr   = 1'b0;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_wrap_count", int'(wrap_count), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // wrap up: 14,15,0,1 counting up
    cyc(14, 1'b1);
    cyc(15, 1'b1);
    expect_evt(C_UP, 0);
    cyc(0, 1'b1);
    chk("wrap_pulse_hi", int'(wrap_pulse), 1);
    chk("wrap_count_up", int'(wrap_count), 1);
    cyc(1, 1'b1);
    chk("wrap_pulse_lo", int'(wrap_pulse), 0);

    // direction change then wrap down: 1,0,15 counting down
    expect_evt(C_DIR, 1);
    cyc(1, 1'b0);
    cyc(0, 1'b0);
    expect_evt(C_DOWN, 15);
    cyc(15, 1'b0);
    chk("wrap_count_down", int'(wrap_count), 0);

    // compare: load 5, hold 5 three cycles, 6, 5
    cmp_val  = 4'd5;
    cmp_load = 1'b1;
    cyc(15, 1'b0);
    cmp_load = 1'b0;
    expect_evt(C_MATCH, 5);
    cyc(5, 1'b0);
    chk("match_pulse_1", int'(match_pulse), 1);
    cyc(5, 1'b0);
    chk("match_hold_no_pulse", int'(match_pulse), 0);
    cyc(5, 1'b0);
    cyc(6, 1'b0);
    expect_evt(C_MATCH, 5);
    cyc(5, 1'b0);
    chk("match_pulse_2", int'(match_pulse), 1);

    // wrap + match + direction change together: only the wrap survives
    cmp_val  = 4'd0;
    cmp_load = 1'b1;
    cyc(15, 1'b0);
    cmp_load = 1'b0;
    expect_evt(C_UP, 0);
    cyc(0, 1'b1);
    chk("prio_drop", int'(drop_count), 2);
    chk("prio_overrun", int'(overrun), 1);
    chk("prio_wrap_count", int'(wrap_count), 1);
    clr_ovr = 1'b1;
    cyc(0, 1'b1);
    clr_ovr = 1'b0;
    chk("clr_drop", int'(drop_count), 0);
    chk("clr_overrun", int'(overrun), 0);

    // stall: five direction changes into a depth-4 FIFO
    evt_ready = 1'b0;
    expect_evt(C_DIR, 1);
    cyc(1, 1'b0);
    expect_evt(C_DIR, 2);
    cyc(2, 1'b1);
    expect_evt(C_DIR, 3);
    cyc(3, 1'b0);
    expect_evt(C_DIR, 4);
    cyc(4, 1'b1);
    cyc(5, 1'b0);
    chk("full_valid", int'(evt_valid), 1);
    chk("full_drop", int'(drop_count), 1);
    chk("full_overrun", int'(overrun), 1);
    chk("full_head_code", int'(evt_code), int'(C_DIR));
    chk("full_head_value", int'(evt_value), 1);
    // full with a pop in the same cycle: the new event is accepted
    evt_ready = 1'b1;
    expect_evt(C_DIR, 6);
    cyc(6, 1'b1);
    chk("full_pop_push_drop", int'(drop_count), 1);
    repeat (5) cyc(6, 1'b1);
    chk("drain_valid", int'(evt_valid), 0);
    chk("drain_queue", exp_q.size(), 0);

    // build up 3 queued events and WRAP_COUNT=3, then reset mid-stream
    evt_ready = 1'b0;
    cyc(15, 1'b1);
    cyc(0, 1'b1);
    cyc(7, 1'b1);
    cyc(15, 1'b1);
    cyc(0, 1'b1);
    cyc(1, 1'b0);
    chk("pre_rst_wrap_count", int'(wrap_count), 3);
    chk("pre_rst_valid", int'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(evt_valid), 0);
    chk("async_rst_wrap_count", int'(wrap_count), 0);
    chk("async_rst_overrun", int'(overrun), 0);
    chk("async_rst_drop", int'(drop_count), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    // first edge after release: 0 -> 15 would look like a wrap down
    cyc(15, 1'b0);
    chk("post_rst_valid", int'(evt_valid), 0);
    chk("post_rst_wrap_pulse", int'(wrap_pulse), 0);
    chk("post_rst_wrap_count", int'(wrap_count), 0);
    // wrap + direction change; compare is disarmed so no match is lost
    expect_evt(C_UP, 0);
    cyc(0, 1'b1);
    chk("post_rst_wrap_count_up", int'(wrap_count), 1);
    chk("post_rst_drop", int'(drop_count), 1);
    repeat (3) cyc(0, 1'b1);
    chk("final_queue", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
Downstream consumer of the up/down synchronous counter's Q bus and UP_DOWN control. Samples the count every clock and detects wrap-around, compare-match and direction-change events. Extends the count with a signed-agnostic wrap (upper-digit) counter and queues events in a small valid/ready FIFO for a display or controller stage.

Parameters:
WIDTH, 5, width of the monitored count (must be >= 2; matches counter WIDTH)
WRAP_WIDTH, 8, width of the wrap (upper-digit) counter
EVT_DEPTH, 4, event FIFO depth (power of 2, >= 2)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  asynchronous, active-low reset
Q_IN  input  WIDTH  counter output, same clock domain
UP_DOWN  input  1  counter direction (1 = up, 0 = down)
CMP_VAL  input  WIDTH  compare value
CMP_LOAD  input  1  load CMP_VAL into compare register and arm compare
CLR_OVR  input  1  clear OVERRUN and DROP_COUNT
EVT_READY  input  1  consumer accepts head event
EVT_VALID  output  1  FIFO non-empty
EVT_CODE  output  2  head event: 00 DIR_CHANGE, 01 WRAP_UP, 10 WRAP_DOWN, 11 MATCH
EVT_VALUE  output  WIDTH  Q_IN captured with the head event
WRAP_COUNT  output  WRAP_WIDTH  upper-digit counter
MATCH_PULSE  output  1  one-cycle pulse per match
WRAP_PULSE  output  1  one-cycle pulse per wrap (either direction)
OVERRUN  output  1  sticky: an event was lost
DROP_COUNT  output  4  saturating count of lost events

Behaviour:
- Reset (RESET low, async): all outputs 0; FIFO empty; compare register 0 and disarmed; q_prev, dir_prev 0; prev_valid 0.
- Every posedge: q_prev <= Q_IN, dir_prev <= UP_DOWN, prev_valid <= 1. No event is detected while prev_valid = 0 (first edge after reset release).
- Detection (combinational on current inputs vs. registered prev, prev_valid = 1):
  - wrap_up: q_prev = all ones and Q_IN = 0.
  - wrap_down: q_prev = 0 and Q_IN = all ones.
  - match: armed, Q_IN = cmp_reg and Q_IN != q_prev. A held value never re-fires.
  - dir_change: UP_DOWN != dir_prev.
- CMP_LOAD: cmp_reg <= CMP_VAL and armed <= 1 at the edge. Match on that same cycle uses the old cmp_reg and old armed state.
- WRAP_COUNT: +1 on wrap_up and -1 on wrap_down, modulo 2^WRAP_WIDTH, at the detection edge.
- MATCH_PULSE and WRAP_PULSE are registered. Each is high for exactly the one cycle after its detection edge.
- Event selection: at most one push per cycle, with priority WRAP > MATCH > DIR_CHANGE. Each lower-priority event detected in the same cycle counts as lost.
- FIFO:
  - Push writes {code, Q_IN}.
  - Pop occurs when EVT_VALID and EVT_READY are both high.
  - EVT_CODE and EVT_VALUE present the head entry registered, stable while EVT_VALID is high and EVT_READY is low.
  - Push while full and no pop: the event is lost.
  - Push while full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Push while empty: EVT_VALID rises the next cycle (1-cycle latency from detection edge).
- Lost events: OVERRUN <= 1 (sticky). DROP_COUNT increments by the number lost that cycle (0..2 from priority, +1 if the selected push is also lost) and saturates at 15.
  - CLR_OVR clears both; any lost events in the same cycle win (apply after clear).
- Reset mid-operation clears the FIFO contents, WRAP_COUNT and the armed state immediately. Events pending at reset are discarded.

Test Plan:
- Setup for all scenarios: WIDTH=4, WRAP_WIDTH=4, EVT_DEPTH=4.
- Reset, then drive Q_IN 14,15,0,1 with UP_DOWN=1 held, EVT_READY=1 -> one WRAP_UP event with EVT_VALUE=0; WRAP_PULSE high for one cycle; WRAP_COUNT=1; no DIR event.
- Q_IN 1,0,15 with UP_DOWN=0 (dir changed from 1 on the Q=1 cycle) -> events DIR_CHANGE (value 1), then WRAP_DOWN (value 15); WRAP_COUNT returns to 0.
- CMP_LOAD with CMP_VAL=5; hold Q_IN=5 for 3 cycles, then 6, then 5 -> exactly two MATCH events, both value 5, and two MATCH_PULSEs.
- Same-cycle wrap + match + dir change (CMP=0, Q_IN 15->0, UP_DOWN toggles) -> only WRAP_UP queued; DROP_COUNT=2; OVERRUN=1; CLR_OVR -> both 0.
- EVT_READY=0 and 5 distinct events -> EVT_VALID high, 4 entries in order, 5th lost (DROP_COUNT=1). Full with READY=1 and a new event -> accepted, no drop.
- Assert RESET low mid-stream with 3 queued events and WRAP_COUNT=3 -> EVT_VALID=0, WRAP_COUNT=0, OVERRUN=0 immediately (asynchronously). First edge after release produces no event even if Q_IN differs.
